// File: rtl/nfc_atom_cal_generator_if.sv
// Request/status bundle between a command issuer and the CA latch generator.
// The issuer drives the request fields; the generator returns ready and last-step.
interface nfc_atom_cal_generator_if #(
    parameter int NumberOfWays = 4
);
    logic                    iStart;
    logic [NumberOfWays-1:0] iTargetWay;
    logic [15:0]             iNumOfData;
    logic                    iCASelect;
    logic [39:0]             iCAData;
    logic                    oReady;
    logic                    oLastStep;

    modport master (
        output iStart, iTargetWay, iNumOfData, iCASelect, iCAData,
        input  oReady, oLastStep
    );

    modport slave (
        input  iStart, iTargetWay, iNumOfData, iCASelect, iCAData,
        output oReady, oLastStep
    );
endinterface

// File: rtl/nfc_atom_cal_generator.sv
// Atomic CLE/ALE latch sequencer: drives CE_n/CLE/ALE/WE_n/DQ for 1..5 CA bytes.
// Define NFC_CAL_CE_KEEP_EN to keep CE_n asserted after completion until the next start.
module nfc_atom_cal_generator #(
    parameter int NumberOfWays = 4,
    parameter int tSetup       = 2,
    parameter int tWP          = 2,
    parameter int tWH          = 2,
    parameter int tHold        = 2
) (
    input  logic                        iSystemClock,
    input  logic                        iReset,
    nfc_atom_cal_generator_if.slave     acgBus,
    output logic [NumberOfWays-1:0]     oCE_n,
    output logic                        oCLE,
    output logic                        oALE,
    output logic                        oWE_n,
    output logic [7:0]                  oDQ,
    output logic                        oDQ_OE
);

`ifdef NFC_CAL_CE_KEEP_EN
    localparam bit CeKeep = 1'b1;
`else
    localparam bit CeKeep = 1'b0;
`endif

    // Timer reload values are (cycles - 1); 0 is treated as 1, anything above 15 saturates.
    localparam int SetupEff = (tSetup < 1) ? 1 : ((tSetup > 15) ? 15 : tSetup);
    localparam int WpEff    = (tWP    < 1) ? 1 : ((tWP    > 15) ? 15 : tWP);
    localparam int WhEff    = (tWH    < 1) ? 1 : ((tWH    > 15) ? 15 : tWH);
    localparam int HoldEff  = (tHold  < 1) ? 1 : ((tHold  > 15) ? 15 : tHold);
    localparam logic [3:0] SetupLoad = 4'(SetupEff - 1);
    localparam logic [3:0] WpLoad    = 4'(WpEff - 1);
    localparam logic [3:0] WhLoad    = 4'(WhEff - 1);
    localparam logic [3:0] HoldLoad  = 4'(HoldEff - 1);

    typedef enum logic [2:0] {IDLE, SETUP, WE_LOW, WE_HIGH, HOLD, DONE} state_t;

    state_t      state;
    logic [3:0]  timer;
    logic [2:0]  remaining;
    logic [31:0] pendingBytes;
    logic [2:0]  clampedCount;
    logic        timerDone;

    assign clampedCount = (acgBus.iNumOfData > 16'd5) ? 3'd5 : acgBus.iNumOfData[2:0];
    assign timerDone    = (timer == 4'd0);

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state            <= IDLE;
            timer            <= 4'd0;
            remaining        <= 3'd0;
            pendingBytes     <= 32'd0;
            acgBus.oReady    <= 1'b1;
            acgBus.oLastStep <= 1'b0;
            oCE_n            <= '1;
            oCLE             <= 1'b0;
            oALE             <= 1'b0;
            oWE_n            <= 1'b1;
            oDQ              <= 8'h00;
            oDQ_OE           <= 1'b0;
        end else begin
            acgBus.oLastStep <= 1'b0;
            case (state)
                IDLE: begin
                    if (acgBus.iStart) begin
                        acgBus.oReady <= 1'b0;
                        remaining     <= clampedCount;
                        pendingBytes  <= acgBus.iCAData[31:0];
                        if (clampedCount == 3'd0) begin
                            // Empty request: report completion without touching the pins.
                            state            <= DONE;
                            acgBus.oLastStep <= 1'b1;
                        end else begin
                            state  <= SETUP;
                            timer  <= SetupLoad;
                            oCE_n  <= ~acgBus.iTargetWay;
                            oCLE   <= acgBus.iCASelect;
                            oALE   <= ~acgBus.iCASelect;
                            oDQ    <= acgBus.iCAData[39:32];
                            oDQ_OE <= 1'b1;
                            oWE_n  <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (timerDone) begin
                        state <= WE_LOW;
                        timer <= WpLoad;
                        oWE_n <= 1'b0;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                WE_LOW: begin
                    if (timerDone) begin
                        state <= WE_HIGH;
                        timer <= WhLoad;
                        oWE_n <= 1'b1;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                WE_HIGH: begin
                    if (timerDone) begin
                        if (remaining > 3'd1) begin
                            // Next byte goes onto DQ together with the WE_n fall.
                            state        <= WE_LOW;
                            timer        <= WpLoad;
                            oWE_n        <= 1'b0;
                            oDQ          <= pendingBytes[31:24];
                            pendingBytes <= {pendingBytes[23:0], 8'h00};
                            remaining    <= remaining - 3'd1;
                        end else begin
                            state <= HOLD;
                            timer <= HoldLoad;
                        end
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                HOLD: begin
                    if (timerDone) begin
                        state            <= DONE;
                        acgBus.oLastStep <= 1'b1;
                        if (!CeKeep) begin
                            oCE_n <= '1;
                        end
                        oCLE   <= 1'b0;
                        oALE   <= 1'b0;
                        oDQ    <= 8'h00;
                        oDQ_OE <= 1'b0;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    acgBus.oReady <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nfc_atom_cal_generator.sv
// Bench for nfc_atom_cal_generator: default-timing instance plus a (1,3,1,4) timing instance,
// directed vector table, reset/busy/CE-keep sequences and randomized requests.
module tb_nfc_atom_cal_generator;

`ifdef NFC_CAL_CE_KEEP_EN
    localparam bit Keep = 1'b1;
`else
    localparam bit Keep = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nfc_atom_cal_generator_if #(.NumberOfWays(4)) bus ();
    nfc_atom_cal_generator_if #(.NumberOfWays(4)) bus2 ();

    logic [3:0] ceA, ceB;
    logic       cleA, cleB, aleA, aleB, weA, weB, oeA, oeB;
    logic [7:0] dqA, dqB;

    nfc_atom_cal_generator #(.NumberOfWays(4)) dut (
        .iSystemClock(clk), .iReset(rst), .acgBus(bus),
        .oCE_n(ceA), .oCLE(cleA), .oALE(aleA), .oWE_n(weA), .oDQ(dqA), .oDQ_OE(oeA)
    );

    nfc_atom_cal_generator #(.NumberOfWays(4), .tSetup(1), .tWP(3), .tWH(1), .tHold(4)) dut2 (
        .iSystemClock(clk), .iReset(rst), .acgBus(bus2),
        .oCE_n(ceB), .oCLE(cleB), .oALE(aleB), .oWE_n(weB), .oDQ(dqB), .oDQ_OE(oeB)
    );

    // View of whichever instance the current transaction targets.
    bit         useAlt;
    logic [3:0] mCe;
    logic       mCle, mAle, mWe, mOe, mReady, mLast;
    logic [7:0] mDq;
    always_comb begin
        mCe    = useAlt ? ceB  : ceA;
        mCle   = useAlt ? cleB : cleA;
        mAle   = useAlt ? aleB : aleA;
        mWe    = useAlt ? weB  : weA;
        mOe    = useAlt ? oeB  : oeA;
        mDq    = useAlt ? dqB  : dqA;
        mReady = useAlt ? bus2.oReady   : bus.oReady;
        mLast  = useAlt ? bus2.oLastStep : bus.oLastStep;
    end

    int errors = 0;
    int checks = 0;
    logic [3:0] expIdleCe [2];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input bit alt, input logic st, input logic [3:0] way, input logic [15:0] n,
                         input logic sel, input logic [39:0] data);
        if (alt) begin
            bus2.iStart = st; bus2.iTargetWay = way; bus2.iNumOfData = n;
            bus2.iCASelect = sel; bus2.iCAData = data;
        end else begin
            bus.iStart = st; bus.iTargetWay = way; bus.iNumOfData = n;
            bus.iCASelect = sel; bus.iCAData = data;
        end
    endtask

    // Reference: completion cycle from the timing rule, with the count clamped to 5.
    function automatic int modelLat(input bit alt, input logic [15:0] n);
        int nb;
        nb = (n > 16'd5) ? 5 : int'(n);
        if (nb == 0) return 1;
        return alt ? (1 + nb * (3 + 1) + 4 + 1) : (2 + nb * (2 + 2) + 2 + 1);
    endfunction

    function automatic int modelPulses(input logic [15:0] n);
        return (n > 16'd5) ? 5 : int'(n);
    endfunction

    task automatic runTxn(input string tag, input bit alt, input logic [3:0] way, input logic [15:0] n,
                          input logic sel, input logic [39:0] data, input int expLat,
                          input int expPulses, input int poke);
        int nb, lat, pulses, lowLen, tw;
        logic [7:0]  bytes [$];
        logic [39:0] d;
        logic [3:0]  activeCe, doneCe;
        bit badDq, badW, badAct, badExcl, prevWe;
        nb = (n > 16'd5) ? 5 : int'(n);
        d = data;
        for (int i = 0; i < nb; i++) begin
            bytes.push_back(d[39:32]);
            d = d << 8;
        end
        tw       = alt ? 3 : 2;
        activeCe = (nb == 0) ? expIdleCe[alt] : ~way;
        doneCe   = (Keep && nb > 0) ? ~way : expIdleCe[alt];
        useAlt   = alt;
        lat = -1; pulses = 0; lowLen = 0; prevWe = 1'b1;
        badDq = 0; badW = 0; badAct = 0; badExcl = 0;
        drive(alt, 1'b1, way, n, sel, data);
        for (int cyc = 1; cyc <= expLat + 12 && lat < 0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                drive(alt, 1'b0, way, n, sel, data);
                check({tag, "_ready_drop"}, mReady, 1'b0);
            end
            if (poke > 0 && cyc == poke) drive(alt, 1'b1, ~way, 16'd1, ~sel, ~data);
            if (poke > 0 && cyc == poke + 1) drive(alt, 1'b0, way, n, sel, data);
            if (mCle && mAle) badExcl = 1;
            if (!mWe && (mCle == mAle)) badExcl = 1;
            if (!mWe) begin
                if (prevWe) pulses++;
                lowLen++;
                if (pulses > nb) badDq = 1;
                else if (mDq !== bytes[pulses-1]) badDq = 1;
            end else if (!prevWe) begin
                if (lowLen != tw) badW = 1;
                lowLen = 0;
            end
            prevWe = mWe;
            if (mLast) begin
                lat = cyc;
                check({tag, "_done_pins"}, {mCe, mCle, mAle, mWe, mOe, mDq},
                      {doneCe, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
            end else if (nb > 0) begin
                if (mCe !== activeCe || mCle !== sel || mAle !== ~sel || mOe !== 1'b1) badAct = 1;
            end else begin
                if (mCe !== activeCe || mOe !== 1'b0 || mCle || mAle || !mWe) badAct = 1;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(expLat));
        check({tag, "_we_pulses"}, 64'(pulses), 64'(expPulses));
        check({tag, "_dq_bytes"}, badDq, 1'b0);
        check({tag, "_we_width"}, badW, 1'b0);
        check({tag, "_active_pins"}, badAct, 1'b0);
        check({tag, "_cle_ale_excl"}, badExcl, 1'b0);
        if (lat > 0) begin
            @(posedge clk); #1;
            check({tag, "_after_done"}, {mReady, mLast, mCe}, {1'b1, 1'b0, doneCe});
        end
        expIdleCe[alt] = doneCe;
    endtask

    typedef struct {
        string       name;
        bit          alt;
        logic [3:0]  way;
        logic [15:0] n;
        logic        sel;
        logic [39:0] data;
        int          expLat;
        int          expPulses;
        int          poke;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"reset_cmd",  0, 4'b0001, 16'd1,     1'b1, 40'hFF_00_00_00_00,  9, 1, 0};
        vecs[1] = '{"addr_burst", 0, 4'b0100, 16'd5,     1'b0, 40'h01_02_03_04_05, 25, 5, 0};
        vecs[2] = '{"clamp7",     0, 4'b0010, 16'd7,     1'b0, 40'hA1_B2_C3_D4_E5, 25, 5, 0};
        vecs[3] = '{"zero",       0, 4'b0001, 16'd0,     1'b1, 40'h12_34_56_78_9A,  1, 0, 0};
        vecs[4] = '{"busy_start", 0, 4'b1000, 16'd3,     1'b1, 40'h11_22_33_44_55, 17, 3, 4};
        vecs[5] = '{"timing",     1, 4'b0001, 16'd2,     1'b1, 40'hC0_FF_EE_00_00, 14, 2, 0};
        vecs[6] = '{"no_way",     0, 4'b0000, 16'd2,     1'b0, 40'h5A_A5_00_00_00, 13, 2, 0};
        vecs[7] = '{"clamp_big",  0, 4'b0100, 16'h8001,  1'b1, 40'h0F_1E_2D_3C_4B, 25, 5, 0};
        vecs[8] = '{"timing_n5",  1, 4'b0010, 16'd5,     1'b0, 40'h99_88_77_66_55, 26, 5, 0};

        useAlt = 0;
        drive(0, 1'b0, 4'b0, 16'd0, 1'b0, 40'd0);
        drive(1, 1'b0, 4'b0, 16'd0, 1'b0, 40'd0);
        expIdleCe[0] = 4'hF;
        expIdleCe[1] = 4'hF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_state_a", {bus.oReady, bus.oLastStep, ceA, cleA, aleA, weA, dqA, oeA},
              {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
        check("reset_state_b", {bus2.oReady, bus2.oLastStep, ceB, cleB, aleB, weB, dqB, oeB},
              {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});

        for (int i = 0; i < 9; i++)
            runTxn(vecs[i].name, vecs[i].alt, vecs[i].way, vecs[i].n, vecs[i].sel, vecs[i].data,
                   vecs[i].expLat, vecs[i].expPulses, vecs[i].poke);

        // Reset during the third of five bytes.
        begin
            int falls;
            bit prev, hit;
            falls = 0; prev = 1; hit = 0; useAlt = 0;
            drive(0, 1'b1, 4'b0100, 16'd5, 1'b0, 40'h01_02_03_04_05);
            for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
                @(posedge clk); #1;
                if (cyc == 1) drive(0, 1'b0, 4'b0100, 16'd5, 1'b0, 40'h01_02_03_04_05);
                if (prev && !weA) falls++;
                prev = weA;
                if (falls == 3) hit = 1;
            end
            check("reset_reached_byte3", hit, 1'b1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("reset_mid_op", {bus.oReady, bus.oLastStep, ceA, cleA, aleA, weA, dqA, oeA},
                  {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
            hit = 0;
            for (int cyc = 0; cyc < 15; cyc++) begin
                @(posedge clk); #1;
                if (bus.oLastStep || !bus.oReady || !weA) hit = 1;
            end
            check("reset_no_laststep", hit, 1'b0);
            expIdleCe[0] = 4'hF;
            expIdleCe[1] = 4'hF;
        end

`ifdef NFC_CAL_CE_KEEP_EN
        runTxn("keep_a", 0, 4'b0010, 16'd1, 1'b1, 40'h70_00_00_00_00, 9, 1, 0);
        repeat (3) @(posedge clk);
        #1 check("keep_idle_ce", ceA, 4'b1101);
        runTxn("keep_b", 0, 4'b1000, 16'd2, 1'b0, 40'h33_44_00_00_00, 13, 2, 0);
        check("keep_switch_ce", ceA, 4'b0111);
`endif

        for (int r = 0; r < 40; r++) begin
            bit          alt;
            logic [3:0]  way;
            logic [15:0] n;
            logic [39:0] data;
            logic        sel;
            int          poke;
            alt  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: way = 4'b0000;
                1: way = 4'b0001;
                2: way = 4'b0010;
                3: way = 4'b0100;
                default: way = 4'b1000;
            endcase
            n    = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            sel  = 1'($urandom_range(0, 1));
            data = {8'($urandom), 32'($urandom)};
            poke = (modelPulses(n) > 0 && $urandom_range(0, 2) == 0) ? 3 : 0;
            runTxn($sformatf("rand%0d", r), alt, way, n, sel, data, modelLat(alt, n), modelPulses(n), poke);
            if (rst) $fatal(1, "FAIL rand: reset unexpectedly high");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
